// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the single write port of the synchronous
// FIFO between NUM_REQ producers. Each producer raises req[i] (holding
// wdata slice i stable) until it sees gnt[i]; the word transfers on the
// clock edge where req[i] & gnt[i]. A producer that also holds lock[i]
// keeps the port for a burst until it drops req or lock.
//
// The FIFO write interface is registered: a word granted at edge t is
// presented on fifo_data_in / fifo_wr_en during the following cycle and
// written by the FIFO at edge t+1. Grants are withheld whenever the FIFO
// could overflow, counting the write already in flight.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   FIFO_WIDTH  data width, matches the FIFO
//   IDX_W       width of the owner index
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   req, lock, wdata          producer side (wdata slice i = requester i)
//   gnt                       one-hot combinational grant
//   fifo_data_in, fifo_wr_en  registered FIFO write port
//   fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow
//                             FIFO status / responses
//   owner                     last granted requester
//   burst                     high while a locked burst holds the port
//   err_overflow, err_noack   sticky error flags, cleared by reset only
//   gnt_cnt                   per-requester 16-bit grant counters
//
// Optional build macro
//   FIFO_ARB_STATS_EN  when defined, gnt_cnt holds saturating grant
//                      counters; otherwise gnt_cnt is tied to zero.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic [IDX_W-1:0]              owner,
    output logic                          burst,
    output logic                          err_overflow,
    output logic                          err_noack,
    output logic [NUM_REQ*16-1:0]         gnt_cnt
);

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0] gnt_idx;
    logic             found;
    logic             space_ok;
    logic             gnt_valid;
    logic             ack_pend;

    // Next index in round-robin order; NUM_REQ need not be a power of two.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        if (int'(i) == NUM_REQ - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // -----------------------------------------------------------------------
    // Grant selection
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        found     = 1'b0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        gnt       = '0;

        // A write still in flight will take the last slot when almostfull,
        // so it must be counted. FIFO reads are ignored: being conservative
        // can only cost a cycle, never an overflow.
        space_ok = !fifo_full && !(fifo_almostfull && fifo_wr_en);

        if (state_q == ARB) begin
            // First requester at or above rr_ptr, wrapping around.
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                    found   = 1'b1;
                    gnt_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
                end
            end
        end else begin
            // Inside a burst only the owner may transfer.
            found   = req[owner];
            gnt_idx = owner;
        end

        // gnt feeds producers combinationally, so it is held off during
        // reset rather than waiting for the first clock.
        gnt_valid = found && space_ok && rst_n;
        if (gnt_valid) begin
            gnt = NUM_REQ'(1) << gnt_idx;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr;
        case (state_q)
            ARB: begin
                if (gnt_valid) begin
                    rr_ptr_d = wrap_inc(gnt_idx);
                    if (lock[gnt_idx]) begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                // Throttling alone keeps the burst; the owner ends it by
                // dropping req or lock. A beat granted with lock low is last.
                if (!req[owner] || !lock[owner]) begin
                    state_d  = ARB;
                    rr_ptr_d = wrap_inc(owner);
                end
            end
            default: state_d = ARB;
        endcase
    end

    // -----------------------------------------------------------------------
    // State, FIFO write port and error flags
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB;
            rr_ptr       <= '0;
            owner        <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            ack_pend     <= 1'b0;
            err_noack    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr     <= rr_ptr_d;
            fifo_wr_en <= gnt_valid;
            if (gnt_valid) begin
                fifo_data_in <= wdata[int'(gnt_idx) * FIFO_WIDTH +: FIFO_WIDTH];
                owner        <= gnt_idx;
            end

            // The FIFO answers a write one cycle after wr_en was presented.
            ack_pend <= fifo_wr_en;
            if (ack_pend && !fifo_wr_ack) begin
                err_noack <= 1'b1;
            end
            if (fifo_overflow) begin
                err_overflow <= 1'b1;
            end
        end
    end

    assign burst = (state_q == BURST);

    // -----------------------------------------------------------------------
    // Optional grant statistics
    // -----------------------------------------------------------------------
`ifdef FIFO_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [15:0] cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (req[g] && gnt[g] && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end

        assign gnt_cnt[g*16 +: 16] = cnt_q;
    end
`else
    assign gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, FIFO_WIDTH=16) with a small
// behavioural model of the 8-deep FIFO write side driving full, almostfull,
// wr_ack and overflow. Inputs change on the falling edge; outputs are read
// 1 ns later, away from the rising (active) edge.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int FIFO_WIDTH = 16;
    localparam int IDX_W      = 2;
    localparam int DEPTH      = 8;

    logic                          clk;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            lock;
    logic [NUM_REQ*FIFO_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_wr_en;
    logic                          fifo_full;
    logic                          fifo_almostfull;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;
    logic [IDX_W-1:0]              owner;
    logic                          burst;
    logic                          err_overflow;
    logic                          err_noack;
    logic [NUM_REQ*16-1:0]         gnt_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO model controls
    logic       rd_en;
    logic       force_noack;
    logic       force_ovf;
    logic [3:0] fcount;
    logic       ack_q;
    logic       ovf_q;
    logic       wr_ok;
    logic       rd_ok;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .FIFO_WIDTH (FIFO_WIDTH),
        .IDX_W      (IDX_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .lock            (lock),
        .wdata           (wdata),
        .gnt             (gnt),
        .fifo_data_in    (fifo_data_in),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_wr_ack     (fifo_wr_ack),
        .fifo_overflow   (fifo_overflow),
        .owner           (owner),
        .burst           (burst),
        .err_overflow    (err_overflow),
        .err_noack       (err_noack),
        .gnt_cnt         (gnt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO write-side model
    assign wr_ok           = fifo_wr_en && (fcount < 4'(DEPTH));
    assign rd_ok           = rd_en && (fcount != 4'd0);
    assign fifo_full       = (fcount == 4'(DEPTH));
    assign fifo_almostfull = (fcount == 4'(DEPTH - 1));
    assign fifo_wr_ack     = ack_q && !force_noack;
    assign fifo_overflow   = ovf_q || force_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcount <= 4'd0;
            ack_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            fcount <= fcount + 4'(wr_ok) - 4'(rd_ok);
            ack_q  <= wr_ok;
            ovf_q  <= fifo_wr_en && (fcount == 4'(DEPTH));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Reset pulse ending just after a falling edge with all producers idle.
    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        req         = '0;
        lock        = '0;
        rd_en       = 1'b0;
        force_noack = 1'b0;
        force_ovf   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        req         = 4'b1111;
        lock        = 4'b0000;
        rd_en       = 1'b0;
        force_noack = 1'b0;
        force_ovf   = 1'b0;
        wdata       = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        #1;
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++; $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000);
        end
        n_checks++;
        if (fifo_wr_en !== 1'b0 || fifo_data_in !== 16'h0000) begin
            n_fail++; $display("FAIL reset_wr: got wr_en=%b data=%h expected 0/0000", fifo_wr_en, fifo_data_in);
        end
        n_checks++;
        if (owner !== 2'd0 || burst !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got owner=%0d burst=%b expected 0/0", owner, burst);
        end
        n_checks++;
        if (err_noack !== 1'b0 || err_overflow !== 1'b0 || gnt_cnt !== 64'd0) begin
            n_fail++; $display("FAIL reset_err: got noack=%b ovf=%b cnt=%h expected 0", err_noack, err_overflow, gnt_cnt);
        end
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        wdata = {16'h4444, 16'hA5A5, 16'h2222, 16'h1111};
        req   = 4'b0100;
        #1;
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++; $display("FAIL single_gnt0: got %b expected %b", gnt, 4'b0100);
        end
        for (int k = 1; k < 3; k++) begin
            @(negedge clk); #1;
            n_checks++;
            if (gnt !== 4'b0100) begin
                n_fail++; $display("FAIL single_gnt%0d: got %b expected %b", k, gnt, 4'b0100);
            end
            n_checks++;
            if (fifo_wr_en !== 1'b1 || fifo_data_in !== 16'hA5A5 || owner !== 2'd2) begin
                n_fail++; $display("FAIL single_wr%0d: got wr_en=%b data=%h owner=%0d expected 1/a5a5/2", k, fifo_wr_en, fifo_data_in, owner);
            end
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        n_checks++;
        if (gnt !== 4'b0000 || fifo_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL single_last: got gnt=%b wr_en=%b expected 0000/1", gnt, fifo_wr_en);
        end
        @(negedge clk); #1;
        n_checks++;
        if (fifo_wr_en !== 1'b0 || fifo_data_in !== 16'hA5A5) begin
            n_fail++; $display("FAIL single_idle: got wr_en=%b data=%h expected 0/a5a5", fifo_wr_en, fifo_data_in);
        end
        n_checks++;
        if (err_noack !== 1'b0 || err_overflow !== 1'b0) begin
            n_fail++; $display("FAIL single_err: got noack=%b ovf=%b expected 0/0", err_noack, err_overflow);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_gnt;
        do_reset();
        wdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req   = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp_gnt = 4'(1 << (k % 4));
            n_checks++;
            if (gnt !== exp_gnt) begin
                n_fail++; $display("FAIL fair_gnt%0d: got %b expected %b", k, gnt, exp_gnt);
            end
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        n_checks++;
        if (owner !== 2'd3 || fifo_data_in !== 16'h4444) begin
            n_fail++; $display("FAIL fair_owner: got owner=%0d data=%h expected 3/4444", owner, fifo_data_in);
        end
    endtask

    task automatic test_burst();
        do_reset();
        wdata = {16'h4444, 16'h3333, 16'hB00B, 16'h1111};
        req   = 4'b1010;
        lock  = 4'b0010;
        #1;
        n_checks++;
        if (gnt !== 4'b0010 || burst !== 1'b0) begin
            n_fail++; $display("FAIL burst_first: got gnt=%b burst=%b expected 0010/0", gnt, burst);
        end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk); #1;
            n_checks++;
            if (gnt !== 4'b0010 || burst !== 1'b1) begin
                n_fail++; $display("FAIL burst_beat%0d: got gnt=%b burst=%b expected 0010/1", k, gnt, burst);
            end
        end
        // Owner drops lock: this beat is still granted and ends the burst.
        @(negedge clk);
        lock = 4'b0000;
        #1;
        n_checks++;
        if (gnt !== 4'b0010 || burst !== 1'b1) begin
            n_fail++; $display("FAIL burst_lastbeat: got gnt=%b burst=%b expected 0010/1", gnt, burst);
        end
        @(negedge clk); #1;
        n_checks++;
        if (gnt !== 4'b1000 || burst !== 1'b0) begin
            n_fail++; $display("FAIL burst_exit: got gnt=%b burst=%b expected 1000/0", gnt, burst);
        end
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic test_backpressure();
        int   grants;
        int   grants2;
        logic gnt_when_full;
        logic saw_ovf;
        do_reset();
        grants        = 0;
        grants2       = 0;
        gnt_when_full = 1'b0;
        saw_ovf       = 1'b0;
        req           = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (gnt[0]) grants++;
            if (fifo_full && gnt != 4'b0000) gnt_when_full = 1'b1;
            if (fifo_overflow) saw_ovf = 1'b1;
        end
        n_checks++;
        if (grants != DEPTH) begin
            n_fail++; $display("FAIL bp_fill: got %0d grants expected %0d", grants, DEPTH);
        end
        n_checks++;
        if (gnt_when_full !== 1'b0 || saw_ovf !== 1'b0) begin
            n_fail++; $display("FAIL bp_full: got gnt_when_full=%b overflow_seen=%b expected 0/0", gnt_when_full, saw_ovf);
        end
        n_checks++;
        if (fifo_full !== 1'b1 || err_overflow !== 1'b0) begin
            n_fail++; $display("FAIL bp_state: got full=%b err_ovf=%b expected 1/0", fifo_full, err_overflow);
        end
        // One read frees one slot: exactly one further grant.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            rd_en = (k == 0);
            #1;
            if (gnt[0]) grants2++;
            if (fifo_overflow) saw_ovf = 1'b1;
        end
        n_checks++;
        if (grants2 != 1 || saw_ovf !== 1'b0 || err_overflow !== 1'b0) begin
            n_fail++; $display("FAIL bp_read: got %0d grants ovf_seen=%b err_ovf=%b expected 1/0/0", grants2, saw_ovf, err_overflow);
        end
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic test_errors();
        do_reset();
        force_noack = 1'b1;
        req         = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk); #1;
        n_checks++;
        if (err_noack !== 1'b0) begin
            n_fail++; $display("FAIL err_noack_early: got %b expected 0", err_noack);
        end
        @(negedge clk); #1;
        n_checks++;
        if (err_noack !== 1'b1) begin
            n_fail++; $display("FAIL err_noack_set: got %b expected 1", err_noack);
        end
        force_noack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (err_noack !== 1'b1 || err_overflow !== 1'b0) begin
            n_fail++; $display("FAIL err_sticky: got noack=%b ovf=%b expected 1/0", err_noack, err_overflow);
        end
        @(negedge clk);
        force_ovf = 1'b1;
        @(negedge clk);
        force_ovf = 1'b0;
        #1;
        n_checks++;
        if (err_overflow !== 1'b1 || err_noack !== 1'b1) begin
            n_fail++; $display("FAIL err_ovf_set: got ovf=%b noack=%b expected 1/1", err_overflow, err_noack);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (err_overflow !== 1'b0 || err_noack !== 1'b0) begin
            n_fail++; $display("FAIL err_clear: got ovf=%b noack=%b expected 0/0", err_overflow, err_noack);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_midburst();
        do_reset();
        req  = 4'b0001;
        lock = 4'b0001;
        @(negedge clk); #1;
        n_checks++;
        if (burst !== 1'b1 || fifo_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL mid_inburst: got burst=%b wr_en=%b expected 1/1", burst, fifo_wr_en);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (burst !== 1'b0 || fifo_wr_en !== 1'b0 || gnt !== 4'b0000) begin
            n_fail++; $display("FAIL mid_reset: got burst=%b wr_en=%b gnt=%b expected 0/0/0000", burst, fifo_wr_en, gnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        lock  = 4'b0000;
        #1;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL mid_rereq: got gnt=%b expected 0001", gnt);
        end
        @(negedge clk); #1;
        n_checks++;
        if (burst !== 1'b0 || fifo_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL mid_after: got burst=%b wr_en=%b expected 0/1", burst, fifo_wr_en);
        end
        req = 4'b0000;
    endtask

    task automatic test_stats();
        int          grants;
        logic [15:0] exp_cnt;
`ifdef FIFO_ARB_STATS_EN
        exp_cnt = 16'd10;
`else
        exp_cnt = 16'd0;
`endif
        do_reset();
        grants = 0;
        rd_en  = 1'b1;
        req    = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (gnt[0]) grants++;
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        n_checks++;
        if (grants != 10) begin
            n_fail++; $display("FAIL stats_grants: got %0d expected 10", grants);
        end
        n_checks++;
        if (gnt_cnt[15:0] !== exp_cnt || gnt_cnt[63:16] !== 48'd0) begin
            n_fail++; $display("FAIL stats_cnt: got %h expected slice0=%h others 0", gnt_cnt, exp_cnt);
        end
        rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_burst();
        test_backpressure();
        test_errors();
        test_reset_midburst();
        test_stats();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single write port of the team's synchronous FIFO (16-bit wide, 8 deep by default) between NUM_REQ producers. Each producer has a req/gnt handshake, with optional burst locking. The arbiter registers the FIFO's data_in/wr_en, throttles on full/almostfull so the FIFO never overflows, and checks the FIFO's wr_ack/overflow responses. It sits between the producer blocks and the FIFO's DUT modport.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
FIFO_WIDTH, 16, data width, matches FIFO
IDX_W, $clog2(NUM_REQ), width of the owner index

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester write request, held until granted
lock  input  NUM_REQ  per-requester burst lock, sampled with req
wdata  input  NUM_REQ*FIFO_WIDTH  packed data, slice i belongs to requester i
gnt  output  NUM_REQ  one-hot combinational grant; the transfer occurs at the clock edge where req[i]&gnt[i]
fifo_data_in  output  FIFO_WIDTH  registered FIFO data_in
fifo_wr_en  output  1  registered FIFO wr_en
fifo_full  input  1  FIFO full
fifo_almostfull  input  1  FIFO almostfull (one slot left)
fifo_wr_ack  input  1  FIFO wr_ack
fifo_overflow  input  1  FIFO overflow
owner  output  IDX_W  index of the last granted requester (registered)
burst  output  1  high while in the BURST state
err_overflow  output  1  sticky, set when fifo_overflow is seen
err_noack  output  1  sticky, set on a missing wr_ack
gnt_cnt  output  NUM_REQ*16  grant counters (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): fifo_wr_en=0, fifo_data_in=0, owner=0, rr_ptr=0, state=ARB, burst=0, err_*=0, gnt_cnt=0. gnt is 0 while rst_n=0.
- space_ok = !fifo_full && !(fifo_almostfull && fifo_wr_en). This is conservative: concurrent reads are ignored. When !space_ok, gnt=0.
- ARB state: if space_ok, grant the first requester with req=1, searching from rr_ptr upward modulo NUM_REQ. At most one gnt bit is high.
- On a grant to i at edge t: fifo_data_in<=wdata[i], fifo_wr_en<=1, owner<=i, rr_ptr<=(i+1)%NUM_REQ. If lock[i]=1, next state is BURST.
- No grant at edge t: fifo_wr_en<=0, and fifo_data_in holds its value.
- Latency: data is granted at edge t, appears at the FIFO at t+1, and is written at edge t+1. Maximum throughput is 1 word per cycle.
- BURST state: only the owner is eligible. gnt[owner]=req[owner]&space_ok.
  - rr_ptr is not advanced during the burst.
  - Exit to ARB, with rr_ptr<=(owner+1)%NUM_REQ, when an edge arrives with req[owner]=0 or lock[owner]=0.
  - A beat granted with lock=0 is the last beat of the burst.
  - Throttling (!space_ok) holds BURST without exiting.
- burst = (state==BURST).
- Ack check: if fifo_wr_en=1 in cycle c and fifo_wr_ack=0 in cycle c+1, set err_noack.
- fifo_overflow=1 in any cycle sets err_overflow.
- Both error flags clear only on reset. Neither error affects arbitration.
- A requester with req=1 and gnt=0 must hold req and its wdata. Dropping req before grant is legal and simply withdraws the request.
- Reset mid-burst: state returns to ARB immediately and the in-flight fifo_wr_en is dropped. The producer must re-request.

Optional Feature:
Macro FIFO_ARB_STATS_EN.
- Defined: gnt_cnt slice i is a 16-bit counter, incremented on every req[i]&gnt[i] edge and saturating at 16'hFFFF. It is reset to 0.
- Undefined: gnt_cnt is tied to 0 and no counter flops are built.

Test Plan:
- Single requester: req[2]=1 for 3 cycles with wdata[2]=16'hA5A5, FIFO empty -> gnt[2] high 3 cycles; fifo_wr_en high on cycles t+1..t+3; fifo_data_in=16'hA5A5; owner=2; err_*=0.
- Fairness: req=4'b1111 continuously, no lock, rr_ptr=0 -> grant order 0,1,2,3,0,1,2,3 over 8 consecutive cycles.
- Burst: req[1]=lock[1]=1 for 4 beats while req[3]=1 -> gnt[1] for 4 beats; burst=1; then lock[1]=0 -> BURST exits, next grant goes to 3.
- Back-pressure: fill the FIFO to depth 8 with no reads -> at most 8 grants; gnt=0 while fifo_full; fifo_overflow is never asserted; err_overflow=0. After one read, exactly one more grant.
- Error flags: force fifo_wr_ack=0 after a write -> err_noack=1 sticky. Pulse fifo_overflow=1 -> err_overflow=1. rst_n low clears both.
- Reset mid-burst, plus the stats variant: assert rst_n=0 during BURST -> state ARB, fifo_wr_en=0 at once. With FIFO_ARB_STATS_EN defined, 10 grants to requester 0 -> gnt_cnt[15:0]=10; without the macro, gnt_cnt=0.
